// File: rtl/fp_align_shifter.sv
// fp_align_shifter: mantissa alignment stage of the single-precision adder
// Ports:
//   clk, rst_n                async active-low reset
//   in_valid / in_ready       operand handshake (ready only in IDLE)
//   a, b                      IEEE-754 single operands
//   exp_diff, exp_borrow      Ea - Eb mod 256 and its borrow (1: Ea < Eb)
//   out_valid / out_ready     result handshake (valid only in DONE)
//   big_sign, small_sign      signs of the larger/smaller-exponent operands
//   big_exp                   exponent of the larger-exponent operand
//   big_man                   {hidden, fraction, 3'b000}
//   small_man                 aligned {hidden, fraction, guard, round, sticky}
//   swapped                   B was selected as the larger operand
module fp_align_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [7:0]  exp_diff,
    input  logic        exp_borrow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        big_sign,
    output logic        small_sign,
    output logic [7:0]  big_exp,
    output logic [26:0] big_man,
    output logic [26:0] small_man,
    output logic        swapped
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rem_q, rem_d;
    logic        big_sign_q, big_sign_d, small_sign_q, small_sign_d, swapped_q, swapped_d;
    logic [7:0]  big_exp_q, big_exp_d;
    logic [26:0] big_man_q, big_man_d, small_man_q, small_man_d;

    logic [31:0] big_op, small_op;
    logic [7:0]  shift;
    logic [4:0]  shift_cap;

    assign big_op    = exp_borrow ? b : a;
    assign small_op  = exp_borrow ? a : b;
    assign shift     = exp_borrow ? 8'd0 - exp_diff : exp_diff;
    // 27 shifts already collapse the whole mantissa into the sticky bit
    assign shift_cap = (shift > 8'd27) ? 5'd27 : shift[4:0];

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        swapped_d    = swapped_q;
        big_exp_d    = big_exp_q;
        big_man_d    = big_man_q;
        small_man_d  = small_man_q;
        case (state_q)
            IDLE: if (in_valid) begin
                big_sign_d   = big_op[31];
                small_sign_d = small_op[31];
                swapped_d    = exp_borrow;
                big_exp_d    = big_op[30:23];
                big_man_d    = {|big_op[30:23], big_op[22:0], 3'b000};
                small_man_d  = {|small_op[30:23], small_op[22:0], 3'b000};
                rem_d        = shift_cap;
                state_d      = (shift_cap == 5'd0) ? DONE : SHIFT;
            end
            SHIFT: begin
                // bit 0 ORs in whatever falls off, so sticky never clears
                small_man_d = {1'b0, small_man_q[26:2], small_man_q[1] | small_man_q[0]};
                rem_d       = rem_q - 5'd1;
                state_d     = (rem_q == 5'd1) ? DONE : SHIFT;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            swapped_q    <= 1'b0;
            big_exp_q    <= '0;
            big_man_q    <= '0;
            small_man_q  <= '0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            swapped_q    <= swapped_d;
            big_exp_q    <= big_exp_d;
            big_man_q    <= big_man_d;
            small_man_q  <= small_man_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign big_sign   = big_sign_q;
    assign small_sign = small_sign_q;
    assign swapped    = swapped_q;
    assign big_exp    = big_exp_q;
    assign big_man    = big_man_q;
    assign small_man  = small_man_q;
endmodule
